fp_operand_queue: RTL and testbench
===================================

FP_OPERAND_QUEUE -- requirements
Module: fp_operand_queue

Interface
REQ-001 Parameter WIDTH, default 32, operand and result width (IEEE-754 single).
REQ-002 Parameter DEPTH, default 4, operand FIFO entries (power of two, at least 2).
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-005 in_valid  input  1  operand pair offered.
REQ-006 in_ready  output  1  queue can accept a pair this cycle.
REQ-007 in_a, in_b  input  WIDTH each  operands.
REQ-008 in_rnd  input  2  rounding mode, carried with its operands.
REQ-009 add_a, add_b  output  WIDTH each  head-entry operands driven to the combinational FP adder.
REQ-010 add_rnd  output  2  head-entry rounding mode to the adder.
REQ-011 add_result  input  WIDTH  adder result for add_a/add_b, valid in the same cycle.
REQ-012 out_valid  output  1  out_result holds an unconsumed result.
REQ-013 out_ready  input  1  consumer accepts out_result.
REQ-014 out_result  output  WIDTH  registered sum.
REQ-015 out_flags  output  3  registered {is_nan, is_inf, is_zero} of out_result.
REQ-016 count  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Push occurs on a rising edge where in_valid and in_ready are both 1; {in_a, in_b, in_rnd} is written at the write pointer.
REQ-018 in_ready SHALL be (count != DEPTH), registered-state only, with no combinational dependence on out_ready.
REQ-019 add_a/add_b/add_rnd SHALL reflect the read-pointer entry combinationally; when the FIFO is empty they SHALL be 0.
REQ-020 Pop condition: (count != 0) and (!out_valid or out_ready).
REQ-021 On pop: out_result <= add_result, out_flags <= classification of add_result, out_valid <= 1, and the read pointer advances.
REQ-022 Without pop, if out_valid and out_ready: out_valid <= 0, with out_result and out_flags held.
REQ-023 Without pop or handshake, out_valid, out_result and out_flags hold; out_result SHALL stay stable while out_valid=1 and out_ready=0.
REQ-024 Classification:
  - is_nan = exponent all ones and fraction nonzero;
  - is_inf = exponent all ones and fraction zero;
  - is_zero = exponent zero and fraction zero (either sign).
REQ-025 Simultaneous push and pop leaves count unchanged; push alone increments count, pop alone decrements it.
REQ-026 Pointers are clog2(DEPTH) bits and wrap from DEPTH-1 to 0.
REQ-027 Latency: a pair pushed at edge k into an empty queue with idle output appears with out_valid=1 after edge k+1 (2 cycles).
REQ-028 Throughput: with out_ready held at 1 and in_valid continuous, one result per cycle and no bubbles.
REQ-029 Push when full is impossible since in_ready=0; in_valid with in_ready=0 SHALL NOT alter state.
REQ-030 Results leave in push order; no entry is dropped or duplicated.

Reset
REQ-031 While rst=1 at a rising edge: count=0, both pointers=0, out_valid=0, out_result=0, out_flags=0; FIFO storage contents are don't-care.
REQ-032 rst has priority over push and pop in the same cycle; queued and in-flight entries are discarded with no out_valid pulse.
REQ-033 in_ready SHALL be 1 in the first cycle after rst deasserts.

Verification
REQ-034 Single op: push A=0x3F800000, B=0x40000000, rnd=0, out_ready=1 -> two cycles later out_valid=1, out_result=0x40400000, out_flags=000.
REQ-035 Backpressure and fill: out_ready=0, push 5 pairs -> in_ready=0 after the 5th push (one result held plus 4 queued), count=4; out_result stays unchanged over 10 cycles.
REQ-036 Drain order: from REQ-035, raise out_ready -> 5 results in push order, one per cycle, count reaches 0, in_ready returns to 1.
REQ-037 Flags: A=0x7F800000, B=0x3F800000 -> out_flags=010; A=0x7FC00000 -> 100; A=0x00000000 -> 001.
REQ-038 Streaming: 20 back-to-back pushes with out_ready=1 -> 20 consecutive out_valid cycles, count never exceeds 1.
REQ-039 Reset mid-operation: assert rst with count=3 and out_valid=1 -> next cycle count=0, out_valid=0, in_ready=1; a fresh push completes per REQ-027.

Source files
------------

// File: rtl/fp_operand_queue.sv
// rtl/fp_operand_queue.sv - operand-pair FIFO feeding a combinational FP adder with a registered result stage
module fp_operand_queue #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_a,
    input  logic [WIDTH-1:0]           in_b,
    input  logic [1:0]                 in_rnd,
    output logic [WIDTH-1:0]           add_a,
    output logic [WIDTH-1:0]           add_b,
    output logic [1:0]                 add_rnd,
    input  logic [WIDTH-1:0]           add_result,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_result,
    output logic [2:0]                 out_flags,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW     = $clog2(DEPTH);
    localparam int CW     = PW + 1;
    localparam int EXP_W  = 8;
    localparam int FRAC_W = WIDTH - 1 - EXP_W;

    logic [WIDTH-1:0] mem_a   [DEPTH];
    logic [WIDTH-1:0] mem_b   [DEPTH];
    logic [1:0]       mem_rnd [DEPTH];

    logic [PW-1:0] wptr;
    logic [PW-1:0] rptr;
    logic [CW-1:0] count_q;
    logic          empty;
    logic          push;
    logic          pop;

    function automatic logic [2:0] classify(input logic [WIDTH-1:0] v);
        logic [EXP_W-1:0]  e;
        logic [FRAC_W-1:0] f;
        e = v[WIDTH-2 -: EXP_W];
        f = v[FRAC_W-1:0];
        classify = {(&e) && (|f), (&e) && !(|f), !(|e) && !(|f)};
    endfunction

    assign empty    = (count_q == '0);
    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready;
    assign pop      = !empty && (!out_valid || out_ready);
    assign count    = count_q;

    assign add_a   = empty ? '0 : mem_a[rptr];
    assign add_b   = empty ? '0 : mem_b[rptr];
    assign add_rnd = empty ? '0 : mem_rnd[rptr];

    // Storage needs no reset: nothing reads an entry before it is written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wptr]   <= in_a;
            mem_b[wptr]   <= in_b;
            mem_rnd[wptr] <= in_rnd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr       <= '0;
            rptr       <= '0;
            count_q    <= '0;
            out_valid  <= 1'b0;
            out_result <= '0;
            out_flags  <= '0;
        end else begin
            if (push)
                wptr <= wptr + PW'(1);
            if (pop)
                rptr <= rptr + PW'(1);

            if (push && !pop)
                count_q <= count_q + CW'(1);
            else if (pop && !push)
                count_q <= count_q - CW'(1);

            // A pop refills the output register in the same cycle it is consumed.
            if (pop) begin
                out_result <= add_result;
                out_flags  <= classify(add_result);
                out_valid  <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_fp_operand_queue.sv
// tb/tb_fp_operand_queue.sv - self-checking bench for fp_operand_queue with a mock adder and scoreboard
module tb_fp_operand_queue;
    localparam int WIDTH = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_a;
    logic [WIDTH-1:0]  in_b;
    logic [1:0]        in_rnd;
    logic [WIDTH-1:0]  add_a;
    logic [WIDTH-1:0]  add_b;
    logic [1:0]        add_rnd;
    logic [WIDTH-1:0]  add_result;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_result;
    logic [2:0]        out_flags;
    logic [$clog2(DEPTH):0] count;

    int passed = 0;
    int total  = 0;
    bit armed  = 1'b0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fp_operand_queue #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_rnd(in_rnd),
        .add_a(add_a), .add_b(add_b), .add_rnd(add_rnd),
        .add_result(add_result),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_flags(out_flags),
        .count(count)
    );

    // Stand-in adder: exact for the named vectors, deterministic and rnd-sensitive otherwise.
    function automatic logic [31:0] model_add(input logic [31:0] a, input logic [31:0] b,
                                              input logic [1:0] rnd);
        if (a == 32'h3F80_0000 && b == 32'h4000_0000) return 32'h4040_0000;
        if (((a >> 23) & 32'hFF) == 32'hFF) return a;
        if (a == 32'h0) return b;
        return a + b + 32'(rnd);
    endfunction

    function automatic logic [2:0] model_flags(input logic [31:0] r);
        int e;
        int f;
        e = int'((r >> 23) & 32'hFF);
        f = int'(r & 32'h007F_FFFF);
        return {e == 255 && f != 0, e == 255 && f == 0, e == 0 && f == 0};
    endfunction

    assign add_result = model_add(add_a, add_b, add_rnd);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: pending results = held output + queued entries; handshakes seen here land on the next edge.
    always @(negedge clk) begin
        if (armed) begin
            check("occupancy", 32'(count) + 32'(out_valid), 32'(exp_q.size()));
            check("in_ready_vs_model", 32'(in_ready), 32'(exp_q.size() != DEPTH + 1));
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    check("result_order", out_result, exp_q[0]);
                    check("result_flags", 32'(out_flags), 32'(model_flags(exp_q[0])));
                    void'(exp_q.pop_front());
                end
            end
            if (!rst && in_valid && in_ready)
                exp_q.push_back(model_add(in_a, in_b, in_rnd));
        end
        if (rst) begin
            exp_q.delete();
            armed = 1'b1;
        end
    end

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rnd;
        logic [31:0] exp_r;
        logic [2:0]  exp_f;
    } vec_t;

    vec_t vecs[7];
    logic [31:0] held;
    int ov_cycles;
    int max_count;

    task automatic push_single(input logic [31:0] a, input logic [31:0] b, input logic [1:0] rnd,
                               input logic [31:0] exp_r, input logic [2:0] exp_f);
        in_valid = 1'b1; in_a = a; in_b = b; in_rnd = rnd;
        step();
        in_valid = 1'b0;
        check("single_count_after_push", 32'(count), 32'd1);
        check("single_out_valid_early", 32'(out_valid), 32'd0);
        check("single_add_a", add_a, a);
        check("single_add_rnd", 32'(add_rnd), 32'(rnd));
        step();
        check("single_out_valid", 32'(out_valid), 32'd1);
        check("single_out_result", out_result, exp_r);
        check("single_out_flags", 32'(out_flags), 32'(exp_f));
        check("single_count_after_pop", 32'(count), 32'd0);
        check("single_add_a_empty", add_a, 32'd0);
        step();
        check("single_out_valid_consumed", 32'(out_valid), 32'd0);
    endtask

    initial begin
        vecs[0] = '{32'h3F80_0000, 32'h4000_0000, 2'd0, 32'h4040_0000, 3'b000};
        vecs[1] = '{32'h7F80_0000, 32'h3F80_0000, 2'd0, 32'h7F80_0000, 3'b010};
        vecs[2] = '{32'h7FC0_0000, 32'h3F80_0000, 2'd0, 32'h7FC0_0000, 3'b100};
        vecs[3] = '{32'h0000_0000, 32'h0000_0000, 2'd0, 32'h0000_0000, 3'b001};
        vecs[4] = '{32'h0000_0000, 32'h8000_0000, 2'd1, 32'h8000_0000, 3'b001};
        vecs[5] = '{32'h1234_5678, 32'h0000_0010, 2'd3, 32'h1234_568B, 3'b000};
        vecs[6] = '{32'h3F80_0000, 32'h3F80_0000, 2'd2, 32'h7F00_0002, 3'b000};

        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_rnd = '0; out_ready = 1'b0;
        step();
        step();
        check("reset_count", 32'(count), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_result", out_result, 32'd0);
        check("reset_out_flags", 32'(out_flags), 32'd0);
        check("reset_add_a", add_a, 32'd0);
        rst = 1'b0;
        check("reset_in_ready", 32'(in_ready), 32'd1);

        out_ready = 1'b1;
        for (int i = 0; i < 7; i++)
            push_single(vecs[i].a, vecs[i].b, vecs[i].rnd, vecs[i].exp_r, vecs[i].exp_f);

        // Backpressure: one held result plus DEPTH queued entries fills the queue.
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1; in_a = 32'h4000_0000 + 32'(i) * 32'h100; in_b = 32'(i + 1); in_rnd = 2'(i);
            step();
        end
        check("fill_in_ready", 32'(in_ready), 32'd0);
        check("fill_count", 32'(count), 32'd4);
        check("fill_out_valid", 32'(out_valid), 32'd1);
        held = out_result;
        in_a = 32'hDEAD_BEEF;
        for (int i = 0; i < 10; i++) begin
            step();
            check("hold_out_result", out_result, held);
        end
        check("hold_count", 32'(count), 32'd4);
        in_valid = 1'b0;

        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("drain_out_valid", 32'(out_valid), 32'd1);
        end
        check("drain_count", 32'(count), 32'd0);
        check("drain_in_ready", 32'(in_ready), 32'd1);
        step();
        check("drain_idle", 32'(out_valid), 32'd0);
        check("drain_model_empty", 32'(exp_q.size()), 32'd0);

        // Streaming: no bubbles, occupancy stays at most one.
        ov_cycles = 0; max_count = 0;
        for (int i = 0; i < 26; i++) begin
            in_valid = (i < 20); in_a = $urandom; in_b = $urandom; in_rnd = 2'($urandom_range(0, 3));
            step();
            check("stream_in_ready", 32'(in_ready), 32'd1);
            if (out_valid) ov_cycles++;
            if (int'(count) > max_count) max_count = int'(count);
        end
        in_valid = 1'b0;
        check("stream_valid_cycles", 32'(ov_cycles), 32'd20);
        check("stream_max_count", 32'(max_count <= 1), 32'd1);

        // Reset mid-operation with count=3 and a held result.
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_a = 32'h3000_0000 + 32'(i); in_b = 32'h10; in_rnd = 2'd0;
            step();
        end
        in_valid = 1'b0;
        check("pre_reset_count", 32'(count), 32'd3);
        check("pre_reset_out_valid", 32'(out_valid), 32'd1);
        rst = 1'b1; out_ready = 1'b1; in_valid = 1'b1;
        step();
        rst = 1'b0; in_valid = 1'b0;
        check("midreset_count", 32'(count), 32'd0);
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_in_ready", 32'(in_ready), 32'd1);
        check("midreset_out_result", out_result, 32'd0);
        push_single(32'h3F80_0000, 32'h4000_0000, 2'd0, 32'h4040_0000, 3'b000);

        // Randomized traffic, checked by the scoreboard.
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 6);
            in_a = $urandom;
            in_b = $urandom;
            in_rnd = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 15) == 0) in_a = 32'h7F80_0000 | 32'($urandom_range(0, 1));
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) step();
        check("random_drained", 32'(exp_q.size()), 32'd0);
        check("random_idle", 32'(out_valid), 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
